// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Oversampling 8N1 receive front end. It synchronises the raw rx line, rejects
// short start-bit glitches, recovers each bit by a 3-sample majority vote
// around mid-bit and presents every good byte to the receive FIFO with a
// single-cycle write strobe. Framing errors, line breaks and FIFO overruns are
// flagged as single-cycle pulses.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   b_tick     in   one-clk pulse at OVS x baud rate
//   rx         in   asynchronous serial input, idles high
//   rx_full    in   receive FIFO full; looked at only on the stop decision
//   rx_done    out  one-clk FIFO write strobe, dout valid in the same cycle
//   dout       out  last received byte, held until the next frame completes
//   frame_err  out  one-clk pulse: stop bit low, data not all zero
//   break_det  out  one-clk pulse: stop bit low, data all zero
//   overrun    out  one-clk pulse: good frame dropped because FIFO was full
//   busy       out  high whenever the receiver is not idle
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low
// START     | qualifying the start bit; vote at tc=9, bit ends at tc=15
// DATA      | shifting DBIT data bits, one per 16 ticks, LSB first
// STOP      | vote on the stop bit at tc=9, then decide the frame outcome
// WAIT_HIGH | stop bit was low; hold off until the line returns high
// ----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int DBIT = 8,
    parameter int OVS  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            b_tick,
    input  logic            rx,
    input  logic            rx_full,
    output logic            rx_done,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [3:0] TC_LAST = 4'(OVS - 1);
    localparam logic [3:0] TC_V0   = 4'd7;
    localparam logic [3:0] TC_V1   = 4'd8;
    localparam logic [3:0] TC_V2   = 4'd9;
    localparam logic [2:0] BC_LAST = 3'(DBIT - 1);

    state_t          r_state;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [3:0]      r_tc;
    logic [2:0]      r_bc;
    logic [DBIT-1:0] r_sr;
    logic [2:0]      r_v;
    logic [DBIT-1:0] r_dout;
    logic            r_rx_done;
    logic            r_frame_err;
    logic            r_break_det;
    logic            r_overrun;
    logic            r_busy;

    state_t          w_state_next;
    logic [3:0]      w_tc_next;
    logic [2:0]      w_bc_next;
    logic [DBIT-1:0] w_sr_next;
    logic [2:0]      w_v_next;
    logic [DBIT-1:0] w_dout_next;
    logic            w_rx_done_next;
    logic            w_frame_err_next;
    logic            w_break_det_next;
    logic            w_overrun_next;
    logic            w_maj;
    logic            w_maj_now;
    logic            w_counting;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Vote over the three captured samples (used at the end of a data bit).
    assign w_maj      = maj3(r_v[0], r_v[1], r_v[2]);
    // At the tc=9 decision the third sample is being captured on this very
    // edge, so take it straight from rx_s rather than from r_v[2].
    assign w_maj_now  = maj3(r_v[0], r_v[1], r_rx_s);
    assign w_counting = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tc        <= '0;
            r_bc        <= '0;
            r_sr        <= '0;
            r_v         <= '0;
            r_dout      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_break_det <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tc        <= w_tc_next;
            r_bc        <= w_bc_next;
            r_sr        <= w_sr_next;
            r_v         <= w_v_next;
            r_dout      <= w_dout_next;
            r_rx_done   <= w_rx_done_next;
            r_frame_err <= w_frame_err_next;
            r_break_det <= w_break_det_next;
            r_overrun   <= w_overrun_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tc_next        = r_tc;
        w_bc_next        = r_bc;
        w_sr_next        = r_sr;
        w_v_next         = r_v;
        w_dout_next      = r_dout;
        w_rx_done_next   = 1'b0;
        w_frame_err_next = 1'b0;
        w_break_det_next = 1'b0;
        w_overrun_next   = 1'b0;

        if (b_tick && w_counting) begin
            if (r_tc == TC_V0) w_v_next[0] = r_rx_s;
            if (r_tc == TC_V1) w_v_next[1] = r_rx_s;
            if (r_tc == TC_V2) w_v_next[2] = r_rx_s;
        end

        case (r_state)
            S_IDLE: begin
                w_tc_next = '0;
                w_bc_next = '0;
                if (!r_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (b_tick) begin
                    w_tc_next = r_tc + 4'd1;
                    if (r_tc == TC_V2 && w_maj_now) begin
                        w_state_next = S_IDLE;
                        w_tc_next    = '0;
                    end else if (r_tc == TC_LAST) begin
                        w_state_next = S_DATA;
                        w_tc_next    = '0;
                    end
                end
            end

            S_DATA: begin
                if (b_tick) begin
                    w_tc_next = r_tc + 4'd1;
                    if (r_tc == TC_LAST) begin
                        w_tc_next = '0;
                        // LSB arrives first, so after DBIT shifts it sits at bit 0.
                        w_sr_next = {w_maj, r_sr[DBIT-1:1]};
                        if (r_bc == BC_LAST) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_bc_next = r_bc + 3'd1;
                        end
                    end
                end
            end

            S_STOP: begin
                if (b_tick) begin
                    w_tc_next = r_tc + 4'd1;
                    // Decide half a bit into the stop bit so the next start
                    // edge is never missed.
                    if (r_tc == TC_V2) begin
                        w_tc_next = '0;
                        if (w_maj_now) begin
                            w_state_next = S_IDLE;
                            if (rx_full) begin
                                w_overrun_next = 1'b1;
                            end else begin
                                w_rx_done_next = 1'b1;
                                w_dout_next    = r_sr;
                            end
                        end else begin
                            w_state_next = S_WAIT_HIGH;
                            if (r_sr == '0) begin
                                w_break_det_next = 1'b1;
                            end else begin
                                w_frame_err_next = 1'b1;
                                w_dout_next      = r_sr;
                            end
                        end
                    end
                end
            end

            S_WAIT_HIGH: begin
                w_tc_next = '0;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tc_next    = '0;
            end
        endcase
    end

    assign rx_done   = r_rx_done;
    assign dout      = r_dout;
    assign frame_err = r_frame_err;
    assign break_det = r_break_det;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler. b_tick fires every 4 clk (64 clk per
// bit). Each frame pushes its expected event (kind, dout) into a queue; a
// monitor pops and compares whenever an event pulse appears, and also checks
// the latency from the rx falling edge to the pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int K_DONE = 0;
    localparam int K_FERR = 1;
    localparam int K_BRK  = 2;
    localparam int K_OVR  = 3;
    localparam int BIT_CLK = 64;
    localparam int LAT_MIN = 617;
    localparam int LAT_MAX = 621;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       b_tick;
    logic       rx;
    logic       rx_full;
    logic       rx_done;
    logic [7:0] dout;
    logic       frame_err;
    logic       break_det;
    logic       overrun;
    logic       busy;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_frame  = 0;
    bit   mon_en   = 1'b0;

    uart_rx_sampler #(.DBIT(8), .OVS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_full   (rx_full),
        .rx_done   (rx_done),
        .dout      (dout),
        .frame_err (frame_err),
        .break_det (break_det),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick is sampled on posedges whose count is a multiple of 4.
    initial begin
        b_tick = 1'b0;
        forever begin
            @(negedge clk);
            b_tick = ((cyc % 4) == 3);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        int   npulse;
        int   kind;
        int   lat;
        exp_t e;
        if (mon_en) begin
            npulse = int'(rx_done) + int'(frame_err) + int'(break_det) + int'(overrun);
            if (npulse != 0) begin
                kind = rx_done ? K_DONE : frame_err ? K_FERR : break_det ? K_BRK : K_OVR;
                n_assert++;
                assert (npulse === 1) else begin
                    n_fail++;
                    $error("FAIL pulse_excl: %0d pulses high, expected 1", npulse);
                end
                n_assert++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_event: kind %0d dout %h at cyc %0d, expected none", kind, dout, cyc);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    lat = cyc - t_frame;
                    n_assert++;
                    assert (kind === e.kind) else begin
                        n_fail++;
                        $error("FAIL event_kind: got %0d expected %0d", kind, e.kind);
                    end
                    n_assert++;
                    assert (dout === e.data) else begin
                        n_fail++;
                        $error("FAIL event_dout: got %h expected %h", dout, e.data);
                    end
                    n_assert++;
                    assert (lat >= LAT_MIN && lat <= LAT_MAX) else begin
                        n_fail++;
                        $error("FAIL event_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives pat[0..nbits-1], one bit per 64 clk, then returns the line high.
    // flip_period: bit period in which the tc=8 sample alone is inverted.
    // rst_k: clk offset at which a one-clk reset is pulsed (-1 for none).
    // busy_k: clk offset at which busy must be high (-1 for none).
    task automatic drive_bits(input logic [15:0] pat, input int nbits,
                              input int flip_period, input int rst_k, input int busy_k);
        logic v;
        int   b;
        repeat (16) @(negedge clk);
        do @(negedge clk); while ((cyc % 4) != 1);
        t_frame = cyc;
        for (int k = 0; k < nbits * BIT_CLK; k++) begin
            if (k > 0) @(negedge clk);
            b = k / BIT_CLK;
            v = pat[b];
            if (b == flip_period && (k % BIT_CLK) >= 35 && (k % BIT_CLK) <= 38) v = ~v;
            rx = v;
            if (k == rst_k) reset = 1'b1;
            if (rst_k >= 0 && k == rst_k + 1) begin
                reset = 1'b0;
                n_assert++;
                assert ({rx_done, frame_err, break_det, overrun, busy, dout} === 13'h0) else begin
                    n_fail++;
                    $error("FAIL mid_reset_outputs: got %b expected all 0",
                           {rx_done, frame_err, break_det, overrun, busy, dout});
                end
            end
            if (k == busy_k) check_bit("busy_in_frame", busy, 1'b1);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s: %0d expected events outstanding, expected 0", tag, q.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rx_full = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        assert ({rx_done, frame_err, break_det, overrun, busy, dout} === 13'h0) else begin
            n_fail++;
            $error("FAIL reset_outputs: got %b expected all 0",
                   {rx_done, frame_err, break_det, overrun, busy, dout});
        end
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);

        // Clean frame 0xA5.
        push_exp(K_DONE, 8'hA5);
        drive_bits({6'b111111, 1'b1, 8'hA5, 1'b0}, 10, -1, -1, 300);
        wait_drain("drain_a5");

        // 20-clk low glitch: false start, back to idle, no event.
        repeat (16) @(negedge clk);
        do @(negedge clk); while ((cyc % 4) != 1);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("glitch_busy_high", busy, 1'b1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check_bit("glitch_busy_low", busy, 1'b0);

        // Stop bit low, non-zero data: framing error.
        push_exp(K_FERR, 8'h3C);
        drive_bits({6'b000000, 1'b0, 8'h3C, 1'b0}, 10, -1, -1, 630);
        wait_drain("drain_ferr");
        repeat (8) @(negedge clk);
        check_bit("ferr_busy_released", busy, 1'b0);

        // Line held low for 12 bit times: one break, then a normal frame.
        push_exp(K_BRK, 8'h3C);
        drive_bits(16'h0000, 12, -1, -1, 700);
        wait_drain("drain_break");
        push_exp(K_DONE, 8'h55);
        drive_bits({6'b111111, 1'b1, 8'h55, 1'b0}, 10, -1, -1, -1);
        wait_drain("drain_55");

        // FIFO full: overrun, dout holds 0x55. Then the same byte accepted.
        rx_full = 1'b1;
        push_exp(K_OVR, 8'h55);
        drive_bits({6'b111111, 1'b1, 8'h7E, 1'b0}, 10, -1, -1, -1);
        wait_drain("drain_ovr");
        rx_full = 1'b0;
        push_exp(K_DONE, 8'h7E);
        drive_bits({6'b111111, 1'b1, 8'h7E, 1'b0}, 10, -1, -1, -1);
        wait_drain("drain_7e");

        // Reset during data bit 4 of 0xF5 (remaining bits all high): no event.
        drive_bits({6'b111111, 1'b1, 8'hF5, 1'b0}, 10, -1, 350, 340);
        repeat (20) @(negedge clk);
        n_assert++;
        assert (dout === 8'h00) else begin
            n_fail++;
            $error("FAIL dout_after_reset: got %h expected 00", dout);
        end
        push_exp(K_DONE, 8'h81);
        drive_bits({6'b111111, 1'b1, 8'h81, 1'b0}, 10, -1, -1, -1);
        wait_drain("drain_81");

        // Single-tick flips at tc=8 masked by the vote.
        push_exp(K_DONE, 8'h5A);
        drive_bits({6'b111111, 1'b1, 8'h5A, 1'b0}, 10, 4, -1, -1);
        wait_drain("drain_5a");
        push_exp(K_DONE, 8'hC3);
        drive_bits({6'b111111, 1'b1, 8'hC3, 1'b0}, 10, 8, -1, -1);
        wait_drain("drain_c3");

        repeat (100) @(negedge clk);
        check_bit("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling serial receiver front end for the AHB UART. Takes the raw asynchronous RsRx line and the 16x oversample tick from the baud generator. Recovers 8N1 frames using a synchronizer, start-bit glitch rejection and 3-sample majority voting. Each good byte is presented to the receive FIFO with a single-cycle write strobe, and framing, break and overrun events are flagged for the status and interrupt logic.

## Interface
Parameters:
- DBIT, 8, data bits per frame; LSB first; 5..8 legal
- OVS, 16, b_tick pulses per bit period; must be 16 (the sample points below are fixed for 16)

Ports:
- clk  in  1  system clock; same net as HCLK
- reset  in  1  synchronous, active-high reset
- b_tick  in  1  one-clk pulse at 16x the baud rate
- rx  in  1  asynchronous serial input; idles high
- rx_full  in  1  receive FIFO full, from the FIFO
- rx_done  out  1  one-clk write strobe to the FIFO; dout valid in the same cycle
- dout  out  DBIT  last received byte; held until the next frame completes
- frame_err  out  1  one-clk pulse: stop bit sampled low and data not all-zero
- break_det  out  1  one-clk pulse: stop bit low and all data bits zero
- overrun  out  1  one-clk pulse: a good frame completed while rx_full=1; the byte is dropped
- busy  out  1  high in every state except IDLE

## Operation
- Synchronizer: two flops on rx give rx_s. Both flops reset to 1.
- Tick counter tc (4 bits) advances only on b_tick. Bit counter bc (3 bits). Shift register sr (DBIT bits).
- Vote register v[2:0] captures rx_s at tc=7, 8 and 9, on the b_tick edge. maj = majority(v).
- IDLE:
  - rx_s=0 → START with tc=0 and bc=0.
- START:
  - On the b_tick where tc=9, evaluate maj.
  - maj=1 → false start; return to IDLE.
  - maj=0 → continue counting.
  - On the b_tick where tc=15 → DATA with tc=0.
- DATA:
  - On the b_tick where tc=15, shift maj in at the MSB (sr <= {maj, sr[DBIT-1:1]}). This places the LSB-first data correctly after DBIT shifts.
  - If bc=DBIT-1 → STOP; otherwise bc increments.
- STOP: on the b_tick where tc=9, evaluate maj. The half-bit early exit lets the receiver resync to the next start bit. Outcomes:
  - maj=1 and rx_full=0 → dout<=sr, rx_done=1, go to IDLE.
  - maj=1 and rx_full=1 → overrun=1, dout unchanged, no rx_done, go to IDLE.
  - maj=0 and sr==0 → break_det=1, go to WAIT_HIGH.
  - maj=0 and sr!=0 → frame_err=1, dout<=sr, go to WAIT_HIGH.
- WAIT_HIGH:
  - rx_s=1 → IDLE.
  - Prevents a stuck-low line from retriggering START.
- Event pulses are mutually exclusive, and at most one fires per frame.
- Reset mid-frame: state=IDLE; tc, bc, sr, v and dout=0; all pulses and busy=0. The partial frame is discarded with no event.

## Timing
- Reset values: rx_done=0, frame_err=0, break_det=0, overrun=0, busy=0, dout=0.
- rx to rx_s latency: 2 clk.
- A falling edge on rx_s enters START on the next clk; busy rises in that same clk.
- All outputs are registered. Event pulses go high in the clk after the deciding b_tick edge, for exactly 1 clk.
- Frame duration from START entry to the STOP decision: (1 + DBIT) × 16 + 10 b_ticks.
- Minimum clk per b_tick: 1 (b_tick may be held high continuously).
- b_tick while in IDLE or WAIT_HIGH: ignored; tc stays 0.
- rx_full is sampled only at the STOP decision edge.

## Test plan
Common setup: b_tick every 4 clk, so one bit period is 64 clk.

- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → exactly one rx_done pulse, dout=0xA5. rx_done occurs 2 + 1 + 9×64 + 10×4 clk ±2 after the rx falling edge. No other pulses.
- Low glitch on rx of 20 clk (≈5 ticks), then line held high → returns to IDLE at tc=9, busy deasserts, no event pulse.
- Send 0x3C with the stop bit driven low → frame_err pulse, dout=0x3C, busy stays high until rx returns high, no rx_done.
- rx held low for 12 bit times → single break_det pulse. No further events until rx goes high, then a following 0x55 frame yields rx_done with dout=0x55.
- With rx_full=1, send 0x7E → overrun pulse, dout keeps its previous value, no rx_done. Repeat with rx_full=0 → rx_done, dout=0x7E.
- Assert reset during DATA bit 4 of a frame → all outputs 0 in the next clk, and the remaining bits produce no event. A following frame 0x81 is received correctly.
- A single-tick flip inside a data bit at tc=8 → majority vote masks it, dout is correct.
